// File: rtl/fetch_unit_pkg.sv
// Shared core definitions: fetch FSM states, next-PC select encodings and base opcodes.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_INC_4    = 2'b00,
        PC_INC_IMM  = 2'b01,
        PC_INC_ALU  = 2'b10,
        PC_INC_RSVD = 2'b11
    } pc_inc_src_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC select: sequential, PC-relative or indirect (bit 0 cleared).
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_inc_src,
    input  logic        pc_branch,
    input  logic [31:0] imm,
    input  logic [31:0] alu_out,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc + PC_STEP;
        case (pc_inc_src_t'(pc_inc_src))
            PC_INC_IMM: if (pc_branch) next_pc = pc + imm;
            PC_INC_ALU: if (pc_branch) next_pc = {alu_out[31:1], 1'b0};
            default:    next_pc = pc + PC_STEP;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request/hold FSM, PC register with write-back commit, retire counter.
//  state | meaning
//  IDLE  | no fetch outstanding, waiting for if_stage
//  REQ   | imem_req asserted, waiting for imem_ready
//  HOLD  | instr valid, waiting for wb_stage to commit next PC
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        if_stage,
    input  logic        wb_stage,
    input  logic [1:0]  pc_inc_src,
    input  logic        pc_branch,
    input  logic [31:0] imm,
    input  logic [31:0] alu_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        stall,
    output logic        misalign,
    output logic [31:0] instret
);

    fetch_state_t state, state_nxt;
    logic [31:0]  next_pc;
    logic         capture;
    logic         commit;

    next_pc_calc u_next_pc_calc (
        .pc         (pc),
        .pc_inc_src (pc_inc_src),
        .pc_branch  (pc_branch),
        .imm        (imm),
        .alu_out    (alu_out),
        .next_pc    (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        stall     = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
        if (!en) begin
            state_nxt = FETCH_IDLE;
            imem_req  = (state == FETCH_REQ);
            stall     = (state == FETCH_REQ);
        end else begin
            case (state)
                FETCH_IDLE: if (if_stage) state_nxt = FETCH_REQ;
                FETCH_REQ: begin
                    imem_req = 1'b1;
                    stall    = 1'b1;
                    if (imem_ready) begin
                        capture   = 1'b1;
                        state_nxt = FETCH_HOLD;
                    end
                end
                FETCH_HOLD: if (wb_stage) begin
                    commit    = 1'b1;
                    state_nxt = FETCH_IDLE;
                end
                default: state_nxt = FETCH_IDLE;
            endcase
        end
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= 32'h0;
            instr_valid <= 1'b0;
        end else if (!en || commit) begin
            instr_valid <= 1'b0;
        end else if (capture) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
        end
    end

    // A misaligned target is refused: pc holds, the fault is latched until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            instret  <= 32'h0;
            misalign <= 1'b0;
        end else if (commit) begin
            if (next_pc[1:0] == 2'b00) begin
                pc      <= next_pc;
                instret <= instret + 32'd1;
            end else begin
                misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, if_stage, wb_stage, pc_branch, imem_ready;
    logic [1:0]  pc_inc_src;
    logic [31:0] imm, alu_out, imem_rdata;
    logic        imem_req, instr_valid, stall, misalign;
    logic [31:0] imem_addr, instr, pc, pc_plus4, instret;

    int total = 0;
    int bad   = 0;

    // model: fetching = request outstanding, holding = word captured awaiting commit
    bit          m_fetching, m_holding, m_mis;
    logic [31:0] m_pc, m_instr, m_instret;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .if_stage   (if_stage),
        .wb_stage   (wb_stage),
        .pc_inc_src (pc_inc_src),
        .pc_branch  (pc_branch),
        .imm        (imm),
        .alu_out    (alu_out),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .stall      (stall),
        .misalign   (misalign),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] target(input logic [31:0] cur, input logic [1:0] sel,
                                           input logic br, input logic [31:0] im,
                                           input logic [31:0] alu);
        if (sel == 2'd1 && br) return cur + im;
        if (sel == 2'd2 && br) return alu & 32'hFFFF_FFFE;
        return cur + 32'd4;
    endfunction

    task automatic model_reset();
        m_fetching = 0; m_holding = 0; m_mis = 0;
        m_pc = 32'h0; m_instr = 32'h0; m_instret = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        if (!en) begin
            m_fetching = 0;
            m_holding  = 0;
        end else if (m_fetching) begin
            if (imem_ready) begin
                m_instr    = imem_rdata;
                m_holding  = 1;
                m_fetching = 0;
            end
        end else if (m_holding) begin
            if (wb_stage) begin
                t = target(m_pc, pc_inc_src, pc_branch, imm, alu_out);
                if (t % 4 == 0) begin
                    m_pc      = t;
                    m_instret = m_instret + 32'd1;
                end else begin
                    m_mis = 1;
                end
                m_holding = 0;
            end
        end else if (if_stage) begin
            m_fetching = 1;
        end
    endtask

    task automatic check_all();
        chk("imem_req",    32'(imem_req),    32'(m_fetching));
        chk("stall",       32'(stall),       32'(m_fetching));
        chk("imem_addr",   imem_addr,        m_pc);
        chk("pc",          pc,               m_pc);
        chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
        chk("instr",       instr,            m_instr);
        chk("instr_valid", 32'(instr_valid), 32'(m_holding));
        chk("misalign",    32'(misalign),    32'(m_mis));
        chk("instret",     instret,          m_instret);
    endtask

    task automatic cyc(input logic e, input logic ifs, input logic wb, input logic [1:0] sel,
                       input logic br, input logic [31:0] im, input logic [31:0] alu,
                       input logic rdy, input logic [31:0] rd);
        en = e; if_stage = ifs; wb_stage = wb; pc_inc_src = sel; pc_branch = br;
        imm = im; alu_out = alu; imem_ready = rdy; imem_rdata = rd;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_cyc();
        cyc(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic fetch_commit(input logic [1:0] sel, input logic br, input logic [31:0] im,
                                input logic [31:0] alu, input int waits, input logic [31:0] word);
        cyc(1, 1, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);
        for (int i = 0; i < waits; i++) cyc(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, $urandom);
        cyc(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, word);
        cyc(1, 0, 1, sel, br, im, alu, 0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; if_stage = 0; wb_stage = 0; pc_inc_src = 0; pc_branch = 0;
        imm = 0; alu_out = 0; imem_ready = 0; imem_rdata = 0;
        model_reset();
        #1;
        check_all();
        #11 rst_n = 1'b1;

        // basic fetch then sequential commit
        cyc(1, 1, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);
        cyc(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 32'h0050_0093);
        chk("basic_instr", instr, 32'h0050_0093);
        chk("basic_valid", 32'(instr_valid), 32'd1);
        chk("basic_pc", pc, 32'h0);
        cyc(1, 0, 1, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("basic_commit_pc", pc, 32'h4);
        chk("basic_instret", instret, 32'd1);

        // three wait states, ready in IDLE/HOLD ignored
        cyc(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 32'hDEAD_BEEF);
        fetch_commit(2'd0, 0, 32'h0, 32'h0, 3, 32'h1234_5678);
        chk("wait_pc", pc, 32'h8);

        // jump to 0x100 then relative branch taken/not taken
        fetch_commit(2'd2, 1, 32'h0, 32'h0000_0100, 0, 32'h0000_006F);
        fetch_commit(2'd1, 1, 32'hFFFF_FFF8, 32'h0, 1, 32'h0000_0063);
        chk("branch_taken_pc", pc, 32'h0000_00F8);
        fetch_commit(2'd2, 1, 32'h0, 32'h0000_0100, 0, 32'h0000_006F);
        fetch_commit(2'd1, 0, 32'hFFFF_FFF8, 32'h0, 0, 32'h0000_0063);
        chk("branch_not_taken_pc", pc, 32'h0000_0104);

        // misaligned indirect target, then aligned one (bit 0 dropped)
        fetch_commit(2'd2, 1, 32'h0, 32'h0000_0203, 0, 32'h0000_0067);
        chk("misalign_set", 32'(misalign), 32'd1);
        chk("misalign_pc", pc, 32'h0000_0104);
        fetch_commit(2'd2, 1, 32'h0, 32'h0000_0201, 0, 32'h0000_0067);
        chk("indirect_pc", pc, 32'h0000_0200);
        chk("misalign_sticky", 32'(misalign), 32'd1);

        // wb and if together in HOLD: commit only, next fetch waits for if_stage
        cyc(1, 1, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);
        cyc(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 32'hAAAA_0013);
        cyc(1, 1, 1, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);
        idle_cyc();
        chk("wb_if_no_req", 32'(imem_req), 32'd0);

        // en dropped in REQ with simultaneous ready
        cyc(1, 1, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);
        cyc(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 32'h5555_5555);
        chk("abort_instr", instr, 32'hAAAA_0013);
        chk("abort_valid", 32'(instr_valid), 32'd0);
        idle_cyc();

        // en dropped in HOLD clears instr_valid
        cyc(1, 1, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);
        cyc(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 32'h0000_1111);
        cyc(0, 0, 1, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);

        // async reset mid-REQ
        cyc(1, 1, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, 32'h0);
        check_all();
        #1 rst_n = 1'b1;
        fetch_commit(2'd0, 0, 32'h0, 32'h0, 0, 32'h0000_0013);
        chk("post_rst_pc", pc, 32'h4);
        chk("post_rst_misalign", 32'(misalign), 32'd0);

        // retire counter wrap
        @(negedge clk);
        force dut.instret = 32'hFFFF_FFFF;
        #1 release dut.instret;
        m_instret = 32'hFFFF_FFFF;
        fetch_commit(2'd0, 0, 32'h0, 32'h0, 0, 32'h0000_0013);
        chk("instret_wrap", instret, 32'h0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [1:0]  s;
            logic [31:0] im, al;
            s  = 2'($urandom_range(0, 3));
            im = ($urandom_range(0, 7) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00} - 32'd512;
            al = ($urandom_range(0, 5) == 0) ? $urandom : {$urandom_range(0, 4095), 2'b00};
            al[0] = 1'($urandom);
            cyc(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom), s, 1'($urandom),
                im, al, 1'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
